// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and bit-period helper.
// Used by both the receiver and the transmitter.
package uart_pkg;
  localparam int DATA_BITS = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous pad input.
// Reset value is a parameter so idle-high lines come out of reset as idle.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first. Finds the start bit on the synchronised line,
// samples every bit at its centre and emits a 1-cycle rx_valid or frame_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_line,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int          CLKS_PER_BIT = clks_per_bit(clk_freq, baud_rate);
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cfg
    $error("uart_rx: clk_freq/baud_rate must give 4..65535 clocks per bit");
  end

  logic        rx_s;
  logic        rx_prev;
  logic [1:0]  state;
  logic [15:0] clk_count;
  logic [2:0]  bit_index;
  logic [7:0]  shift;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_line),
    .q     (rx_s)
  );

  // rx_prev starts at 1 so a line held low never looks like a fresh start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift     <= '0;
      data      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
      rx_prev   <= 1'b1;
    end else begin
      rx_prev   <= rx_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            state     <= ST_START;
            clk_count <= '0;
            rx_busy   <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_count == HALF_LAST) begin
            clk_count <= '0;
            bit_index <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
            end else begin
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        ST_DATA: begin
          if (clk_count == BIT_LAST) begin
            shift[bit_index] <= rx_s;
            clk_count        <= '0;
            if (bit_index == 3'(DATA_BITS - 1)) state <= ST_STOP;
            else bit_index <= bit_index + 3'd1;
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
        default: begin
          if (clk_count == BIT_LAST) begin
            if (rx_s) begin
              data     <= shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state     <= ST_IDLE;
            rx_busy   <= 1'b0;
            clk_count <= '0;
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end
      endcase
    end
  end
endmodule
